// File: rtl/de2_ram_pkg.sv
// Shared constants and state encoding for the DE2 32x8 two-port RAM write side.
package de2_ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// ADDR_W-bit up-counter with enable, synchronous clear and terminal-count flag.
module wrap_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  logic [ADDR_W-1:0] count_q;

  // Clear wins over enable so a wrap-back to zero can be forced in any cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + ADDR_W'(1);
    end
  end

  assign count = count_q;
  assign tc    = &count_q;

endmodule

// File: rtl/ram_seq_writer.sv
// Streams bytes into sequential RAM addresses with wrap-around, or bulk-fills
// every word with a constant; drives the RAM write port with registered signals.
module ram_seq_writer
  import de2_ram_pkg::*;
#(
  parameter int DATA_W = de2_ram_pkg::DATA_W,
  parameter int ADDR_W = de2_ram_pkg::ADDR_W,
  parameter int DEPTH  = de2_ram_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_fill,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wren,
  output logic              busy,
  output logic              fill_done,
  output logic              wrap,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] LevelMax = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic              in_ready_q, wren_q, busy_q, fill_done_q, wrap_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q, fill_val_q;
  logic [ADDR_W:0]   level_q;

  logic              handshake, fillStart, fillLast;
  logic [ADDR_W-1:0] ptr, fillIdx;
  logic              ptrTc, fillTc;

  assign handshake = (state_q == IDLE) && in_ready_q && in_valid;
  assign fillStart = (state_q == IDLE) && start_fill;
  assign fillLast  = (state_q == FILL) && fillTc;

  wrap_counter #(.ADDR_W(ADDR_W)) u_ptr (
    .clock  (clock),
    .reset  (reset),
    .clear  (fillLast),
    .enable (handshake),
    .count  (ptr),
    .tc     (ptrTc)
  );

  wrap_counter #(.ADDR_W(ADDR_W)) u_fill_idx (
    .clock  (clock),
    .reset  (reset),
    .clear  (fillStart),
    .enable (state_q == FILL),
    .count  (fillIdx),
    .tc     (fillTc)
  );

  // in_ready and busy follow the state one edge late, so they only flip back
  // the edge after the final fill write has been presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      fill_done_q <= 1'b0;
      wrap_q      <= 1'b0;
      fill_val_q  <= '0;
      level_q     <= '0;
    end else begin
      wren_q      <= 1'b0;
      wrap_q      <= 1'b0;
      fill_done_q <= 1'b0;
      in_ready_q  <= (state_q == IDLE) && !start_fill;
      busy_q      <= (state_q == FILL) || start_fill;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            wr_addr_q <= ptr;
            wr_data_q <= in_data;
            wren_q    <= 1'b1;
            wrap_q    <= ptrTc;
            if (level_q != LevelMax) begin
              level_q <= level_q + (ADDR_W+1)'(1);
            end
          end
          if (start_fill) begin
            fill_val_q <= fill_value;
            state_q    <= FILL;
          end
        end
        FILL: begin
          wr_addr_q <= fillIdx;
          wr_data_q <= fill_val_q;
          wren_q    <= 1'b1;
          if (fillTc) begin
            fill_done_q <= 1'b1;
            level_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wren      = wren_q;
  assign busy      = busy_q;
  assign fill_done = fill_done_q;
  assign wrap      = wrap_q;
  assign level     = level_q;

endmodule

// File: tb/tb_ram_seq_writer.sv
// Directed self-checking bench for ram_seq_writer: reset, streaming, wrap,
// fill, overlapping requests and reset during fill.
module tb_ram_seq_writer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_fill;
  logic [7:0] fill_value;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wren;
  logic       busy;
  logic       fill_done;
  logic       wrap;
  logic [5:0] level;

  int checks = 0;
  int failures = 0;

  ram_seq_writer dut (
    .clock      (clock),
    .reset      (reset),
    .start_fill (start_fill),
    .fill_value (fill_value),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wren       (wren),
    .busy       (busy),
    .fill_done  (fill_done),
    .wrap       (wrap),
    .level      (level)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, then let the next rising edge happen and
  // settle so the outputs reflect that edge.
  task automatic applyStimulus(input logic rst, input logic sf, input logic [7:0] fv,
                               input logic v, input logic [7:0] d);
    reset      = rst;
    start_fill = sf;
    fill_value = fv;
    in_valid   = v;
    in_data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; start_fill = 1'b0; fill_value = '0; in_valid = 1'b0; in_data = '0;

    // Reset held for three edges with busy inputs: everything must stay zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'hAB);
      checkOutput("rstReady", in_ready, 0);
      checkOutput("rstWren", wren, 0);
      checkOutput("rstAddr", wr_addr, 0);
      checkOutput("rstData", wr_data, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", fill_done, 0);
      checkOutput("rstWrap", wrap, 0);
      checkOutput("rstLevel", level, 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("relReady", in_ready, 1);
    checkOutput("relWren", wren, 0);
    checkOutput("relLevel", level, 0);

    // Three back-to-back stream bytes land at addresses 0..2.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
    checkOutput("s0Wren", wren, 1);
    checkOutput("s0Addr", wr_addr, 0);
    checkOutput("s0Data", wr_data, 8'h11);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h22);
    checkOutput("s1Wren", wren, 1);
    checkOutput("s1Addr", wr_addr, 1);
    checkOutput("s1Data", wr_data, 8'h22);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h33);
    checkOutput("s2Wren", wren, 1);
    checkOutput("s2Addr", wr_addr, 2);
    checkOutput("s2Data", wr_data, 8'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h99);
    checkOutput("sIdleWren", wren, 0);
    checkOutput("sHoldAddr", wr_addr, 2);
    checkOutput("sHoldData", wr_data, 8'h33);
    checkOutput("sLevel", level, 3);

    // Fresh reset, then 33 bytes: wrap on address 31, byte 0x20 to address 0.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("wRelReady", in_ready, 1);
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'(i));
      checkOutput($sformatf("wAddr%0d", i), wr_addr, i % 32);
      checkOutput($sformatf("wData%0d", i), wr_data, i);
      checkOutput($sformatf("wWrap%0d", i), wrap, (i == 31) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("wWrapClear", wrap, 0);
    checkOutput("wLevelSat", level, 32);

    // Fill with 0xA5 while the stream pointer sits at 1.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    checkOutput("fStartBusy", busy, 1);
    checkOutput("fStartReady", in_ready, 0);
    checkOutput("fStartWren", wren, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h5A, 1'b0, 8'h00);
      checkOutput($sformatf("fWren%0d", i), wren, 1);
      checkOutput($sformatf("fAddr%0d", i), wr_addr, i);
      checkOutput($sformatf("fData%0d", i), wr_data, 8'hA5);
      checkOutput($sformatf("fDone%0d", i), fill_done, (i == 31) ? 1 : 0);
      checkOutput($sformatf("fBusy%0d", i), busy, 1);
      checkOutput($sformatf("fReady%0d", i), in_ready, 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("fExitBusy", busy, 0);
    checkOutput("fExitReady", in_ready, 1);
    checkOutput("fExitWren", wren, 0);
    checkOutput("fExitDone", fill_done, 0);
    checkOutput("fExitLevel", level, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h77);
    checkOutput("fNextAddr", wr_addr, 0);
    checkOutput("fNextData", wr_data, 8'h77);
    checkOutput("fNextLevel", level, 1);

    // Stream byte and fill request on the same edge; noise during the fill.
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1, 8'h5C);
    checkOutput("cWren", wren, 1);
    checkOutput("cAddr", wr_addr, 1);
    checkOutput("cData", wr_data, 8'h5C);
    checkOutput("cBusy", busy, 1);
    checkOutput("cReady", in_ready, 0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, (i == 5 || i == 6), 8'h00, (i >= 5 && i <= 20), 8'hEE);
      checkOutput($sformatf("cAddr%0d", i), wr_addr, i);
      checkOutput($sformatf("cData%0d", i), wr_data, 8'hFF);
      checkOutput($sformatf("cDone%0d", i), fill_done, (i == 31) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("cExitWren", wren, 0);
    checkOutput("cExitBusy", busy, 0);
    checkOutput("cExitLevel", level, 0);

    // Reset while fill write 10 is on the bus aborts with no fill_done.
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    end
    checkOutput("rfAddr10", wr_addr, 10);
    checkOutput("rfData10", wr_data, 8'h3C);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("rfWren", wren, 0);
    checkOutput("rfDone", fill_done, 0);
    checkOutput("rfBusy", busy, 0);
    checkOutput("rfAddr", wr_addr, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("rfRelWren", wren, 0);
    checkOutput("rfRelDone", fill_done, 0);
    checkOutput("rfRelReady", in_ready, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h99);
    checkOutput("rfNextAddr", wr_addr, 0);
    checkOutput("rfNextData", wr_data, 8'h99);
    checkOutput("rfNextWren", wren, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
